sl_receiver_fifo: RTL
=====================

# sl_receiver_fifo

Parametrised successor to the single-word SL receiver: decodes the two-wire SL line (zeroes line, ones line, idle high, active-low pulses) with a glitch filter, runtime word length and optional odd-parity check, and stores each completed word plus its error tag in a receive FIFO instead of a single buffer. Sits between the SL line pins and the host register interface. Adds word-gap timeout, overflow tracking and an interrupt output.

## Interface
- MAX_BITS, 32: maximum data bits per word (8..32); width of rd_data.
- FIFO_DEPTH, 8: FIFO entries, power of two, ≥2.
- FILTER_LEN, 3: consecutive equal samples needed to change a filtered line level.
- STROBE_DLY, 4: clk cycles from symbol start to classification strobe.
- MAX_PULSE, 12: max clk cycles from symbol start until both lines high again.
- GAP_TIMEOUT, 64: max idle clk cycles between symbols inside a word.

- clk  in  1  system clock (16 MHz). One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- serial_line_zeroes_a  in  1  async zeroes line; low pulse = 0 bit.
- serial_line_ones_a  in  1  async ones line; low pulse = 1 bit.
- cfg_wr  in  1  config write strobe.
- cfg_bits  in  6  requested data bits per word.
- cfg_pce  in  1  parity check enable.
- act_bits  out  6  active word length; reset 8.
- act_pce  out  1  active parity enable; reset 1.
- rd_en  in  1  pop FIFO head.
- rd_data  out  MAX_BITS  head data, show-ahead; 0 when empty.
- rd_status  out  3  head tag {LEV, LEN, PEF}; 0 when empty.
- empty  out  1  FIFO empty; reset 1.
- count  out  $clog2(FIFO_DEPTH)+1  entries stored; reset 0.
- overflow  out  1  sticky, word dropped on full FIFO; reset 0.
- ovf_clr  in  1  clears overflow.
- busy  out  1  word in progress (bit_cnt≠0 or state≠IDLE); reset 0.
- irq  out  1  registered !empty | overflow; reset 0.

## Operation
- Input path: 2-flop synchroniser per line (reset value 1), then stable-count filter; filtered level changes after FILTER_LEN equal synchronised samples.
- Symbol start: filtered lines go from both-high to any low.
- FSM: IDLE, SAMPLE, WAIT_END. Reset → IDLE, bit_cnt=0, cyc=0.
- IDLE: on symbol start → SAMPLE, cyc=1. If bit_cnt≠0, gap counter runs; reaching GAP_TIMEOUT pushes {LEN} entry, data 0, bit_cnt=0.
- SAMPLE: when cyc==STROBE_DLY classify filtered (zeroes, ones): (1,0)→bit 1; (0,1)→bit 0; (0,0)→stop; (1,1)→level error. Then → WAIT_END (level error → IDLE).
- Data bits shift in LSB first; bit_cnt+1. Bit at position cfg+1 is parity; bits beyond act_bits+1 still counted (for length check) but discarded.
- Stop: bit_cnt≠act_bits+1 → push {LEN}, data 0. Else if act_pce and count of ones in data+parity is even → push {PEF} with data. Else push {000} with data. Data right-aligned, bits ≥ act_bits zero, parity bit excluded. bit_cnt cleared.
- Level error: push {LEV}, data 0, bit_cnt cleared. Also raised in WAIT_END if both lines not high by cyc==MAX_PULSE (then → IDLE).
- WAIT_END: both filtered high → IDLE.
- Config: cfg_wr captured into pending register; applied when busy==0 (same cycle if already idle). cfg_bits <8 or >MAX_BITS: write ignored entirely.
- FIFO: push on full drops word, sets overflow. Push and pop same cycle: both occur (on full, pop frees slot, push accepted). rd_en on empty ignored. ovf_clr and new overflow same cycle: overflow stays 1.

## Timing
- Line edge → filtered edge: FILTER_LEN+2 clk.
- Filtered start → strobe: STROBE_DLY clk.
- Push registered at strobe edge; empty falls, count increments the next cycle; irq one cycle after that.
- rd_en pop: count/rd_data update next cycle.
- rst_n assertion mid-word: all state, FIFO pointers, flags cleared immediately; partial word lost; config returns to 8/1.

## Test plan
- Default cfg, send 0xA5 LSB-first, parity 1, stop -> one entry rd_data=0xA5, rd_status=000, irq=1.
- Same with parity 0 -> rd_data=0xA5, rd_status=PEF; with act_pce=0 -> status 000.
- 7 bits then stop -> rd_data=0, status=LEN; 3 bits then 64-cycle idle -> status=LEN.
- 2-cycle low glitch on ones line (FILTER_LEN=3) -> no entry, busy stays 0; 20-cycle low on ones line -> LEV entry.
- 9 words without reads (depth 8) -> count=8, overflow=1, reads return first 8 in order; ovf_clr -> overflow=0.
- cfg_wr bits=16 during word -> act_bits stays 8 until stop, then 16; cfg_bits=40 -> ignored.

Source files
------------

// File: rtl/sl_receiver_fifo_if.sv
// Line pins plus host register bundle for sl_receiver_fifo.
// The slave modport is the receiver's view; the master modport is the host's view.
interface sl_receiver_fifo_if #(
  parameter int MAX_BITS   = 32,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                serial_line_zeroes_a;
  logic                serial_line_ones_a;
  logic                cfg_wr;
  logic [5:0]          cfg_bits;
  logic                cfg_pce;
  logic [5:0]          act_bits;
  logic                act_pce;
  logic                rd_en;
  logic [MAX_BITS-1:0] rd_data;
  logic [2:0]          rd_status;
  logic                empty;
  logic [CW-1:0]       count;
  logic                overflow;
  logic                ovf_clr;
  logic                busy;
  logic                irq;

  modport slave (
    input  serial_line_zeroes_a, serial_line_ones_a, cfg_wr, cfg_bits, cfg_pce,
           rd_en, ovf_clr,
    output act_bits, act_pce, rd_data, rd_status, empty, count, overflow, busy, irq
  );

  modport master (
    output serial_line_zeroes_a, serial_line_ones_a, cfg_wr, cfg_bits, cfg_pce,
           rd_en, ovf_clr,
    input  act_bits, act_pce, rd_data, rd_status, empty, count, overflow, busy, irq
  );
endinterface

// File: rtl/sl_receiver_fifo.sv
// SL two-wire line receiver: glitch-filtered symbol decode, runtime word length,
// odd-parity check, and a show-ahead receive FIFO of {status, data} entries.
module sl_receiver_fifo #(
  parameter int MAX_BITS    = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 3,
  parameter int STROBE_DLY  = 4,
  parameter int MAX_PULSE   = 12,
  parameter int GAP_TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst_n,
  sl_receiver_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam int YW = $clog2(MAX_PULSE + 1);
  localparam logic [2:0] TAG_LEV = 3'b100;
  localparam logic [2:0] TAG_LEN = 3'b010;
  localparam logic [2:0] TAG_PEF = 3'b001;

  typedef enum logic [1:0] {IDLE, SAMPLE, WAIT_END} state_t;
  state_t r_state, w_next;

  // Index 0 = zeroes line, index 1 = ones line.
  logic [1:0]         r_s1, r_s2, r_filt;
  logic [1:0][FW-1:0] r_fcnt;
  logic               r_prev_hi;
  logic               w_hi, w_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= 2'b11;
      r_s2      <= 2'b11;
      r_filt    <= 2'b11;
      r_fcnt    <= '0;
      r_prev_hi <= 1'b1;
    end else begin
      r_s1      <= {bus.serial_line_ones_a, bus.serial_line_zeroes_a};
      r_s2      <= r_s1;
      r_prev_hi <= w_hi;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_filt[i])
          r_fcnt[i] <= '0;
        else if (r_fcnt[i] == FW'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_s2[i];
          r_fcnt[i] <= '0;
        end else
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
      end
    end
  end

  assign w_hi    = &r_filt;
  assign w_start = r_prev_hi & ~w_hi;

  logic [YW-1:0]       r_cyc;
  logic [GW-1:0]       r_gap;
  logic [5:0]          r_bit_cnt;
  logic [MAX_BITS-1:0] r_data;
  logic                r_par;
  logic [5:0]          r_act_bits;
  logic                r_act_pce;
  logic                w_bit, w_stop, w_lev, w_gap_to, w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_bit    = 1'b0;
    w_stop   = 1'b0;
    w_lev    = 1'b0;
    w_gap_to = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_bit_cnt != '0 && r_gap == GW'(GAP_TIMEOUT - 1)) w_gap_to = 1'b1;
        if (w_start) w_next = SAMPLE;
      end
      SAMPLE: if (r_cyc == YW'(STROBE_DLY)) begin
        unique case (r_filt)
          2'b01, 2'b10: begin w_bit  = 1'b1; w_next = WAIT_END; end
          2'b00:        begin w_stop = 1'b1; w_next = WAIT_END; end
          2'b11:        begin w_lev  = 1'b1; w_next = IDLE;     end
        endcase
      end
      WAIT_END: begin
        if (w_hi) w_next = IDLE;
        else if (r_cyc == YW'(MAX_PULSE)) begin
          w_lev  = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_busy = (r_bit_cnt != '0) || (r_state != IDLE);

  logic                r_push;
  logic [2:0]          r_push_tag;
  logic [MAX_BITS-1:0] r_push_data;

  // Bit value is the level of the zeroes line: a low ones line means '1'.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc       <= '0;
      r_gap       <= '0;
      r_bit_cnt   <= '0;
      r_data      <= '0;
      r_par       <= 1'b0;
      r_push      <= 1'b0;
      r_push_tag  <= '0;
      r_push_data <= '0;
    end else begin
      r_push <= 1'b0;
      r_cyc  <= (r_state == IDLE) ? YW'(1) : r_cyc + 1'b1;
      r_gap  <= (r_state == IDLE && r_bit_cnt != '0 && !w_gap_to) ? r_gap + 1'b1 : '0;
      if (w_gap_to || w_stop || w_lev) begin
        r_bit_cnt   <= '0;
        r_data      <= '0;
        r_par       <= 1'b0;
        r_push      <= 1'b1;
        r_push_data <= '0;
        if (w_lev)
          r_push_tag <= TAG_LEV;
        else if (w_gap_to || r_bit_cnt != r_act_bits + 6'd1)
          r_push_tag <= TAG_LEN;
        else begin
          r_push_data <= r_data;
          r_push_tag  <= (r_act_pce && !r_par) ? TAG_PEF : 3'b000;
        end
      end else if (w_bit) begin
        if (r_bit_cnt != 6'h3f) r_bit_cnt <= r_bit_cnt + 6'd1;
        if (r_bit_cnt < r_act_bits)  r_data <= r_data | (MAX_BITS'(r_filt[0]) << r_bit_cnt);
        if (r_bit_cnt <= r_act_bits) r_par  <= r_par ^ r_filt[0];
      end
    end
  end

  // Config changes are deferred until no word is in flight.
  logic       r_pend, r_pend_pce, w_cfg_ok;
  logic [5:0] r_pend_bits;

  assign w_cfg_ok = bus.cfg_wr && bus.cfg_bits >= 6'd8 && bus.cfg_bits <= 6'(MAX_BITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_bits  <= 6'd8;
      r_act_pce   <= 1'b1;
      r_pend      <= 1'b0;
      r_pend_bits <= 6'd8;
      r_pend_pce  <= 1'b1;
    end else if (!w_busy && (w_cfg_ok || r_pend)) begin
      r_act_bits <= w_cfg_ok ? bus.cfg_bits : r_pend_bits;
      r_act_pce  <= w_cfg_ok ? bus.cfg_pce  : r_pend_pce;
      r_pend     <= 1'b0;
    end else if (w_cfg_ok) begin
      r_pend      <= 1'b1;
      r_pend_bits <= bus.cfg_bits;
      r_pend_pce  <= bus.cfg_pce;
    end
  end

  logic [MAX_BITS+2:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wp, r_rp;
  logic [CW-1:0]       r_cnt;
  logic                r_ovf, r_irq;
  logic                w_empty, w_full, w_pop, w_wr;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
  assign w_pop   = bus.rd_en & ~w_empty;
  assign w_wr    = r_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= {r_push_tag, r_push_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_wr)  r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_pop);
      r_ovf <= (r_push & w_full & ~w_pop) | (r_ovf & ~bus.ovf_clr);
      r_irq <= ~w_empty | r_ovf;
    end
  end

  assign bus.rd_data   = w_empty ? '0 : r_mem[r_rp][MAX_BITS-1:0];
  assign bus.rd_status = w_empty ? '0 : r_mem[r_rp][MAX_BITS+2:MAX_BITS];
  assign bus.empty     = w_empty;
  assign bus.count     = r_cnt;
  assign bus.overflow  = r_ovf;
  assign bus.busy      = w_busy;
  assign bus.irq       = r_irq;
  assign bus.act_bits  = r_act_bits;
  assign bus.act_pce   = r_act_pce;
endmodule
